// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write/read arbiters: FSM state encoding and
// the width of the per-requester statistics counters.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set bit of req scanning upward from
// ptr+1 (wrapping at N). idx is meaningful only when any is high.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [2:0]   idx,
  output logic         any
);

  // Scan N candidates after the pointer; the first valid one wins.
  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = 3'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-level write arbiter in front of a FIFO. A requester is picked in
// round-robin order and holds the FIFO write port until its last beat lands.
// Optional per-requester beat counters are built when FIFO_ARB_STATS_EN is
// defined; otherwise beat_cnt is tied to zero.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                      wr_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      full,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         din,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic [NUM_REQ*CNT_W-1:0]  beat_cnt
);

  arb_state_e         state;
  logic [2:0]         rr_ptr;
  logic [2:0]         pick_idx;
  logic               pick_any;
  logic               locked;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] xfer;
  logic               last_xfer;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // rst gates the data path immediately so a packet in flight cannot
  // squeeze out another beat during the reset cycle.
  assign locked = (state == LOCKED) && !rst;

  // One-hot grant decode; avoids indexing with a 3-bit id when NUM_REQ < 8.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign grant_oh[i] = locked && (grant_id == 3'(i));
  end

  assign req_ready = grant_oh & {NUM_REQ{~full}};
  assign xfer      = req_valid & req_ready;
  assign wr_en     = |xfer;
  assign last_xfer = |(xfer & req_last);

  // Mux the granted requester's data onto din; zero when no grant is held.
  always_comb begin
    din = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_oh[i]) din = req_data[i*DATA_W +: DATA_W];
  end

  // Grant FSM: pick in IDLE, hold until the last beat transfers.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 3'(NUM_REQ - 1);
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            state    <= LOCKED;
            busy     <= 1'b1;
          end
        end
        LOCKED: begin
          if (last_xfer) begin
            rr_ptr <= grant_id;
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    // Saturating count of beats accepted from this requester.
    always_ff @(posedge wr_clk) begin
      if (rst)
        cnt <= '0;
      else if (xfer[i] && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + CNT_W'(1);
    end
    assign beat_cnt[i*CNT_W +: CNT_W] = cnt;
  end
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, FIFO write data width.
REQ-003 SHALL have port wr_clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester beat valid.
REQ-006 SHALL have port req_data  input  NUM_REQ*DATA_W  per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port req_last  input  NUM_REQ  per-requester last-beat-of-packet flag.
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester beat accept.
REQ-009 SHALL have port full  input  1  FIFO write-side full flag.
REQ-010 SHALL have port wr_en  output  1  FIFO write strobe.
REQ-011 SHALL have port din  output  DATA_W  FIFO write data.
REQ-012 SHALL have port grant_id  output  3  index of the current or last granted requester.
REQ-013 SHALL have port busy  output  1  high while a packet grant is held.
REQ-014 SHALL have port beat_cnt  output  NUM_REQ*16  per-requester accepted-beat counters.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-016 In IDLE with any req_valid high, SHALL select the first valid requester in round-robin order starting at rr_ptr+1 (mod NUM_REQ), register it into grant_id, and enter LOCKED next cycle.
REQ-017 In IDLE, SHALL hold req_ready at all zeros and wr_en at 0; grant latency is exactly one cycle.
REQ-018 In LOCKED, SHALL drive req_ready[grant_id] = ~full combinationally; all other req_ready bits SHALL be 0.
REQ-019 SHALL drive wr_en = req_valid[grant_id] & req_ready[grant_id] and din = req_data of grant_id in LOCKED; din SHALL be 0 when not LOCKED.
REQ-020 A beat transfers on any cycle with wr_en high; the FSM SHALL never assert wr_en while full is high.
REQ-021 On a transfer with req_last[grant_id] high, SHALL return to IDLE next cycle and set rr_ptr = grant_id.
REQ-022 SHALL hold the grant through idle gaps (req_valid low) and full stalls until the last beat transfers; packets are never interleaved.
REQ-023 Requester valid deasserting in IDLE before the grant registers: SHALL still enter LOCKED and wait for that requester.
REQ-024 busy SHALL equal (state == LOCKED).

Reset
REQ-025 On rst, SHALL enter IDLE, set rr_ptr = NUM_REQ-1 (requester 0 highest priority first), grant_id = 0, busy = 0, wr_en = 0, req_ready = 0, din = 0, beat_cnt = 0.
REQ-026 rst asserted mid-packet SHALL abandon the packet with no further wr_en; the FIFO itself is not reset by this block.

Configuration
REQ-027 Macro FIFO_ARB_STATS_EN defined: each beat_cnt[i] SHALL increment by 1 on every transfer from requester i, saturating at 16'hFFFF.
REQ-028 Macro FIFO_ARB_STATS_EN undefined: beat_cnt SHALL be tied to all zeros and no counter flops SHALL be synthesized.

Structure
REQ-029 Shared package fifo_arb_pkg SHALL hold the FSM state encoding (IDLE=0, LOCKED=1) and the counter width constant CNT_W = 16.
REQ-030 The round-robin pick SHALL be one sub-module rr_pick (inputs req vector, pointer; output index and any-valid), reusable by the read side.

Verification
REQ-031 Reset: hold rst 2 cycles with all req_valid = 4'b1111 -> wr_en, req_ready, busy, beat_cnt all 0 during and 1 cycle after.
REQ-032 Single packet: requester 2 sends 0x11,0x22,0x33 (last on 0x33), full = 0 -> grant_id = 2 after 1 cycle, three consecutive wr_en pulses with din 0x11,0x22,0x33, busy drops next cycle.
REQ-033 Round-robin: all four valid with 1-beat packets after reset -> grant order 0,1,2,3,0; one idle cycle between grants.
REQ-034 Full stall: full = 1 for 5 cycles mid-packet of requester 1 -> wr_en and req_ready[1] = 0 those 5 cycles, grant held, data resumes unchanged.
REQ-035 Reset mid-packet: rst after 2 of 4 beats -> no further wr_en, rr_ptr = NUM_REQ-1, next grant goes to requester 0 if valid.
REQ-036 Stats (FIFO_ARB_STATS_EN): 70000 beats from requester 3 -> beat_cnt[3] = 16'hFFFF, others 0; macro undefined -> beat_cnt stays 0.
